bfu_operand_feeder: RTL and testbench

Operand feeder that sits directly upstream of the 4-lane butterfly unit in two-operand modes: pointwise multiply (mode 2) and add/sub (mode 3). It consumes a stream of 12-bit coefficients, reduces each one to canonical form, and packs it into 96-bit words. It then drives the butterfly's pre-load/load strobes, stage sequence, type and twiddle coefficient for each 8-coefficient block.

---
 rtl/bfu_operand_feeder.sv | 162 ++++++++++++++++
 tb/tb_bfu_operand_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bfu_operand_feeder.sv
// Reduces and packs 12-bit coefficients into 8-lane words and sequences butterfly strobes, stage and twiddle per block.
// Strobes are decoded from the registered state; s_ready is high only while filling, so upstream stalls during preload/load/issue.
module bfu_operand_feeder #(
    parameter int NUM_BLOCKS = 32,
    parameter int BLK_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op_mode,
    input  logic              op_sub,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [11:0]       s_data,
    output logic              zeta_rd_en,
    output logic [BLK_W-1:0]  zeta_rd_addr,
    input  logic [23:0]       zeta_rd_data,
    output logic [1:0]        bfu_mode,
    output logic              bfu_type,
    output logic [2:0]        bfu_stage,
    output logic [95:0]       bfu_in_data,
    output logic [23:0]       bfu_in_coef,
    output logic              bfu_pre_load,
    output logic              bfu_load,
    output logic              issue_valid,
    output logic              busy,
    output logic              done,
    output logic              mode_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_A,
        S_PRELOAD,
        S_FILL_B,
        S_LOAD,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [11:0]      Q_MOD    = 12'd3329;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    state_t            state;
    logic [BLK_W-1:0]  blk;
    logic [2:0]        lane_cnt;
    logic [1:0]        iss_cnt;
    logic [7:0][11:0]  pack;
    logic [23:0]       zeta;
    logic              zeta_pend;
    logic [1:0]        mode_q;
    logic              type_q;
    logic              mode_err_q;

    logic              filling;
    logic              accept;
    logic [11:0]       reduced;
    logic              is_mult;
    logic              iss_last;

    assign filling  = (state == S_FILL_A) || (state == S_FILL_B);
    assign accept   = s_valid && filling;
    assign reduced  = (s_data >= Q_MOD) ? (s_data - Q_MOD) : s_data;
    assign is_mult  = (mode_q == 2'd2);
    assign iss_last = is_mult ? (iss_cnt == 2'd3) : (iss_cnt == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            blk        <= '0;
            lane_cnt   <= '0;
            iss_cnt    <= '0;
            pack       <= '0;
            zeta       <= '0;
            zeta_pend  <= 1'b0;
            mode_q     <= '0;
            type_q     <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            mode_err_q <= 1'b0;
            // ROM answers one cycle after the PRELOAD read, i.e. during the first FILL_B cycle
            zeta_pend  <= (state == S_PRELOAD);
            if (zeta_pend) begin
                zeta <= zeta_rd_data;
            end
            if (accept) begin
                pack[lane_cnt] <= reduced;
                lane_cnt       <= lane_cnt + 3'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_mode[1]) begin
                            mode_q   <= op_mode;
                            type_q   <= op_mode[0] && op_sub;
                            blk      <= '0;
                            lane_cnt <= '0;
                            iss_cnt  <= '0;
                            state    <= S_FILL_A;
                        end else begin
                            mode_err_q <= 1'b1;
                        end
                    end
                end
                S_FILL_A: begin
                    if (accept && lane_cnt == 3'd7) begin
                        state <= S_PRELOAD;
                    end
                end
                S_PRELOAD: begin
                    state <= S_FILL_B;
                end
                S_FILL_B: begin
                    if (accept && lane_cnt == 3'd7) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    iss_cnt <= '0;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    iss_cnt <= iss_cnt + 2'd1;
                    if (iss_last) begin
                        iss_cnt <= '0;
                        blk     <= blk + 1'b1;
                        state   <= (blk == LAST_BLK) ? S_DONE : S_FILL_A;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // MULT walks stages 2,3,0,1; ADDSUB walks 0,1
    always_comb begin
        bfu_stage = 3'd0;
        if (state == S_ISSUE) begin
            bfu_stage = is_mult ? {1'b0, 2'(iss_cnt + 2'd2)} : {1'b0, iss_cnt};
        end
    end

    assign s_ready      = filling;
    assign zeta_rd_en   = (state == S_PRELOAD);
    assign zeta_rd_addr = (state == S_PRELOAD) ? blk : '0;
    assign bfu_mode     = mode_q;
    assign bfu_type     = type_q;
    assign bfu_in_data  = pack;
    assign bfu_in_coef  = zeta;
    assign bfu_pre_load = (state == S_PRELOAD);
    assign bfu_load     = (state == S_LOAD);
    assign issue_valid  = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign mode_err     = mode_err_q;

endmodule

// File: tb/tb_bfu_operand_feeder.sv
// Directed bench for bfu_operand_feeder: MULT/ADDSUB streams, gaps, illegal mode, reset abort, start while busy.
module tb_bfu_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op_mode;
    logic        op_sub;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        zeta_rd_en;
    logic [4:0]  zeta_rd_addr;
    logic [23:0] zeta_rd_data;
    logic [1:0]  bfu_mode;
    logic        bfu_type;
    logic [2:0]  bfu_stage;
    logic [95:0] bfu_in_data;
    logic [23:0] bfu_in_coef;
    logic        bfu_pre_load;
    logic        bfu_load;
    logic        issue_valid;
    logic        busy;
    logic        done;
    logic        mode_err;

    int          n_chk = 0;
    int          n_err = 0;
    logic [95:0] first_pre;
    logic [95:0] first_load;

    always #5 clk = ~clk;

    bfu_operand_feeder #(.NUM_BLOCKS(32), .BLK_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op_mode(op_mode), .op_sub(op_sub),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .zeta_rd_en(zeta_rd_en), .zeta_rd_addr(zeta_rd_addr), .zeta_rd_data(zeta_rd_data),
        .bfu_mode(bfu_mode), .bfu_type(bfu_type), .bfu_stage(bfu_stage),
        .bfu_in_data(bfu_in_data), .bfu_in_coef(bfu_in_coef),
        .bfu_pre_load(bfu_pre_load), .bfu_load(bfu_load), .issue_valid(issue_valid),
        .busy(busy), .done(done), .mode_err(mode_err)
    );

    // Twiddle ROM: word b = {b+1, b+17}, registered read
    always @(posedge clk) begin
        if (zeta_rd_en) zeta_rd_data <= {12'(zeta_rd_addr + 5'd0) + 12'd1, 12'(zeta_rd_addr + 5'd0) + 12'd17};
    end

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] all_outs();
        return {21'd0, s_ready, zeta_rd_en, zeta_rd_addr, bfu_mode, bfu_type, bfu_stage,
                bfu_in_data, bfu_in_coef, bfu_pre_load, bfu_load, issue_valid, busy, done, mode_err};
    endfunction

    // MULT stream: A = running index, B = 1. ADDSUB stream: 3329, 4095, 3328, 0 repeating.
    function automatic logic [11:0] coef(input logic [1:0] mode, input int k);
        if (mode == 2'd2) begin
            if ((k % 16) < 8) return 12'((k / 16) * 8 + (k % 16));
            return 12'd1;
        end
        case (k % 4)
            0: return 12'd3329;
            1: return 12'd4095;
            2: return 12'd3328;
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [95:0] exp_word(input logic [1:0] mode, input int b, input bit is_b);
        logic [95:0] w;
        logic [11:0] raw;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            raw = coef(mode, b * 16 + (is_b ? 8 : 0) + i);
            w[i*12 +: 12] = (raw >= 12'd3329) ? raw - 12'd3329 : raw;
        end
        return w;
    endfunction

    task automatic run_op(input logic [1:0] mode, input logic sub, input bit gaps,
                          input int abort_blk, input bit poke, input int exp_len, input string nm);
        int  acc = 0, npre = 0, nload = 0, niss = 0, done_cyc = -1;
        int  bad_pre = 0, bad_load = 0, bad_stage = 0, bad_coef = 0, bad_rdy = 0, bad_attr = 0;
        int  per, b, stray;
        bit  prev_pre = 1'b0;
        logic [2:0] exp_st;
        per = (mode == 2'd2) ? 4 : 2;
        start = 1'b1; op_mode = mode; op_sub = sub; s_valid = 1'b0;
        tick();
        start = 1'b0;
        check({nm, "_busy_start"}, busy, 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bfu_pre_load) begin
                if (npre == 0) first_pre = bfu_in_data;
                if (bfu_in_data !== exp_word(mode, npre, 1'b0)) bad_pre++;
                if (s_ready) bad_rdy++;
                npre++;
            end
            if (bfu_load) begin
                if (nload == 0) first_load = bfu_in_data;
                if (bfu_in_data !== exp_word(mode, nload, 1'b1)) bad_load++;
                if (s_ready) bad_rdy++;
                nload++;
            end
            if (issue_valid) begin
                b = niss / per;
                if (abort_blk >= 0 && b == abort_blk) begin
                    rst = 1'b1; s_valid = 1'b0;
                    tick();
                    check({nm, "_outs_after_rst"}, all_outs(), 0);
                    rst = 1'b0;
                    stray = 0;
                    for (int j = 0; j < 40; j++) begin
                        tick();
                        if (done || busy) stray++;
                    end
                    check({nm, "_idle_after_rst"}, stray, 0);
                    return;
                end
                exp_st = (mode == 2'd2) ? 3'((niss % 4 + 2) % 4) : 3'(niss % 2);
                if (bfu_stage !== exp_st) bad_stage++;
                if (bfu_in_coef !== {12'(b + 1), 12'(b + 17)}) bad_coef++;
                if (bfu_mode !== mode || bfu_type !== (mode == 2'd3 && sub)) bad_attr++;
                if (s_ready) bad_rdy++;
                niss++;
            end else if (bfu_stage !== 3'd0) begin
                bad_stage++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start   = poke && prev_pre && npre == 3;
            op_mode = start ? 2'd3 : mode;
            s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            s_data  = coef(mode, acc);
            if (s_valid && s_ready) acc++;
            prev_pre = bfu_pre_load;
            tick();
        end
        s_valid = 1'b0; start = 1'b0;
        if (exp_len > 0) check({nm, "_len"}, done_cyc + 1, exp_len);
        else check({nm, "_done_seen"}, done_cyc >= 0, 1);
        check({nm, "_npre"}, npre, 32);
        check({nm, "_nload"}, nload, 32);
        check({nm, "_niss"}, niss, 32 * per);
        check({nm, "_pre_words"}, bad_pre, 0);
        check({nm, "_load_words"}, bad_load, 0);
        check({nm, "_stages"}, bad_stage, 0);
        check({nm, "_coef"}, bad_coef, 0);
        check({nm, "_rdy_stall"}, bad_rdy, 0);
        check({nm, "_mode_type"}, bad_attr, 0);
        tick();
        check({nm, "_idle_after"}, {busy, done}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_mode = 2'd0; op_sub = 1'b0; s_valid = 1'b0; s_data = '0;
        tick(); tick(); tick();
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        tick();

        run_op(2'd2, 1'b0, 1'b0, -1, 1'b0, 705, "mult");
        check("mult_blk0_a", first_pre,
              {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1, 12'd0});
        check("mult_blk0_b", first_load, {8{12'd1}});

        run_op(2'd3, 1'b1, 1'b0, -1, 1'b0, 641, "addsub");
        check("addsub_blk0_a", first_pre,
              {12'd0, 12'd3328, 12'd766, 12'd0, 12'd0, 12'd3328, 12'd766, 12'd0});

        run_op(2'd2, 1'b0, 1'b1, -1, 1'b0, -1, "gaps");

        for (int m = 0; m < 2; m++) begin
            start = 1'b1; op_mode = 2'(m);
            tick();
            start = 1'b0;
            check($sformatf("illegal%0d_err", m), mode_err, 1);
            check($sformatf("illegal%0d_busy_rdy", m), {busy, s_ready}, 0);
            tick();
            check($sformatf("illegal%0d_err_clear", m), {mode_err, busy, s_ready}, 0);
        end

        run_op(2'd2, 1'b0, 1'b0, 5, 1'b0, 705, "abort");
        run_op(2'd2, 1'b0, 1'b0, -1, 1'b0, 705, "clean");
        run_op(2'd2, 1'b0, 1'b0, -1, 1'b1, 705, "poke");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
